// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RCV  = 1'b1
    } rx_state_t;

    localparam int UART_Q_DEPTH = 128;
    localparam int BAUD_W       = 13;

    // Sample index of the stop bit (start = 1, data = 2..9, stop = 10)
    localparam logic [3:0] RX_LAST_BIT = 4'd10;

endpackage

// File: rtl/uart_rx_fifo_q.sv
// rtl/uart_rx_fifo_q.sv - 128x8 dual-port receive queue storage with asynchronous read
import uart_pkg::*;

module UART_Q (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [UART_Q_DEPTH];

    // Synchronous write port; storage needs no reset since the pointers gate validity
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a 128-entry byte queue with sticky error flags
import uart_pkg::*;

module uart_rx_fifo (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud_reload,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [7:0]        rdata,
    output logic              rx_rdy,
    output logic [7:0]        entries,
    output logic              frame_err,
    output logic              overrun
);

    logic              rx_ff1_q, rx_ff2_q, rx_prev_q;
    rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_reg_q, shift_reg_d;
    logic [7:0]        wrt_ptr_q, wrt_ptr_d;
    logic [7:0]        rd_ptr_q, rd_ptr_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              start_edge;
    logic [3:0]        bit_cnt_inc;
    logic              byte_valid;
    logic              frame_bad;
    logic [7:0]        fill;
    logic              q_empty, q_full;
    logic              do_pop, do_push, do_drop;

    // Two-stage synchronizer plus a delayed copy for falling-edge detection; idle-high reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_ff1_q  <= RX;
            rx_ff2_q  <= rx_ff1_q;
            rx_prev_q <= rx_ff2_q;
        end
    end

    assign start_edge  = rx_prev_q & ~rx_ff2_q;
    assign bit_cnt_inc = bit_cnt_q + 4'd1;

    // Deframer next state: half-bit delay to the start sample, then one sample per bit period
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        byte_valid  = 1'b0;
        frame_bad   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = RCV;
                    baud_cnt_d = baud_reload >> 1;
                    bit_cnt_d  = 4'd0;
                end
            end
            RCV: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = baud_reload;
                    bit_cnt_d  = bit_cnt_inc;
                    if (bit_cnt_q == 4'd0) begin
                        // Start bit must still be low, otherwise it was a glitch
                        if (rx_ff2_q) begin
                            state_d = IDLE;
                        end
                    end else if (bit_cnt_inc == RX_LAST_BIT) begin
                        state_d = IDLE;
                        if (rx_ff2_q) begin
                            byte_valid = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else begin
                        // LSB arrives first, so shifting in at the MSB leaves it aligned after 8 bits
                        shift_reg_d = {rx_ff2_q, shift_reg_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill    = wrt_ptr_q - rd_ptr_q;
    assign q_empty = (fill == 8'h00);
    assign q_full  = (fill == 8'h80);
    assign do_pop  = rd_en & ~q_empty;
    // A pop in the same cycle frees a slot first, so a full queue still accepts the byte
    assign do_push = byte_valid & (~q_full | do_pop);
    assign do_drop = byte_valid & q_full & ~do_pop;

    // Pointer and sticky-flag next state; a new error outranks a clear in the same cycle
    always_comb begin
        wrt_ptr_d   = wrt_ptr_q + {7'd0, do_push};
        rd_ptr_d    = rd_ptr_q + {7'd0, do_pop};
        frame_err_d = frame_bad | (frame_err_q & ~clr_err);
        overrun_d   = do_drop | (overrun_q & ~clr_err);
    end

    // Receive FSM, datapath and queue bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            shift_reg_q <= 8'h00;
            wrt_ptr_q   <= 8'h00;
            rd_ptr_q    <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
            wrt_ptr_q   <= wrt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    UART_Q u_q (
        .clk   (clk),
        .we    (do_push),
        .waddr (wrt_ptr_q[6:0]),
        .wdata (shift_reg_q),
        .raddr (rd_ptr_q[6:0]),
        .rdata (rdata)
    );

    assign rx_rdy    = ~q_empty;
    assign entries   = fill;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic [12:0] baud_reload;
    logic        rd_en;
    logic        clr_err;
    logic [7:0]  rdata;
    logic        rx_rdy;
    logic [7:0]  entries;
    logic        frame_err;
    logic        overrun;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .baud_reload (baud_reload),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .rdata       (rdata),
        .rx_rdy      (rx_rdy),
        .entries     (entries),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq[$];
    bit         m_ferr;
    bit         m_ovr;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8N1 frame on the pin; caller starts just after a clock edge
    task automatic send_frame(input logic [7:0] b, input bit stop);
        int per;
        per = int'(baud_reload) + 1;
        RX = 1'b0;
        repeat (per) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (per) @(posedge clk);
            #1;
        end
        RX = stop;
        repeat (per) @(posedge clk);
        #1;
        RX = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (!stop)                     m_ferr = 1'b1;
        else if (mq.size() < 128)      mq.push_back(b);
        else                           m_ovr = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit stop);
        @(posedge clk);
        #1;
        send_frame(b, stop);
        model_frame(b, stop);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".entries"}, int'(entries), mq.size());
        check_eq({tag, ".rx_rdy"}, int'(rx_rdy), int'(mq.size() != 0));
        check_eq({tag, ".frame_err"}, int'(frame_err), int'(m_ferr));
        check_eq({tag, ".overrun"}, int'(overrun), int'(m_ovr));
        if (mq.size() != 0) check_eq({tag, ".rdata"}, int'(rdata), int'(mq[0]));
    endtask

    task automatic pop_one(input string tag);
        check_eq({tag, ".pop_rdata"}, int'(rdata), int'(mq[0]));
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        int stop_cycle;
        logic [7:0] b;
        bit st;

        rst_n = 1'b0;
        RX = 1'b1;
        baud_reload = 13'd15;
        rd_en = 1'b0;
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");

        // Single clean byte
        frame(8'hA5, 1'b1);
        check_state("a5");
        check_eq("a5.rdata_exact", int'(rdata), 8'hA5);
        pop_one("a5");
        check_state("a5_popped");

        // Short low glitch is rejected at the start-bit sample
        @(posedge clk);
        #1;
        RX = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_state("false_start");

        // Bad stop bit: byte discarded, sticky flag, then cleared
        frame(8'h3C, 1'b0);
        check_state("ferr");
        check_eq("ferr.flag", int'(frame_err), 1);
        clear_errors();
        check_state("ferr_clr");

        // Randomized frames, reloads, pops and clears
        for (int i = 0; i < 24; i++) begin
            baud_reload = 13'($urandom_range(7, 24));
            b  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            frame(b, st);
            if (mq.size() != 0 && $urandom_range(0, 2) == 0) pop_one("rnd");
            if ($urandom_range(0, 5) == 0) clear_errors();
            check_state("rnd");
        end
        while (mq.size() != 0) pop_one("rnd_drain");
        clear_errors();
        check_state("rnd_done");

        // Fill past capacity
        baud_reload = 13'd7;
        for (int i = 0; i <= 128; i++) begin
            frame(8'(i), 1'b1);
        end
        check_state("full");
        check_eq("full.entries128", int'(entries), 128);
        check_eq("full.overrun", int'(overrun), 1);
        check_eq("full.head0", int'(rdata), 0);
        clear_errors();

        // Pop in the exact stop-sample cycle while full: write must succeed
        stop_cycle = 3 + (int'(baud_reload) >> 1) + 9 * (int'(baud_reload) + 1);
        check_eq("simul.head", int'(rdata), int'(mq[0]));
        @(posedge clk);
        #1;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (stop_cycle) @(posedge clk);
                #1;
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
            end
        join
        void'(mq.pop_front());
        mq.push_back(8'hC3);
        repeat (2) @(posedge clk);
        #1;
        check_state("simul");
        check_eq("simul.overrun0", int'(overrun), 0);
        while (mq.size() != 0) pop_one("full_drain");
        check_state("drained");

        // Reset in mid-frame, then a clean byte
        baud_reload = 13'd15;
        @(posedge clk);
        #1;
        RX = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            RX = 1'(i & 1);
            repeat (16) @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        RX = 1'b1;
        mq.delete();
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state("midreset");
        repeat (5) @(posedge clk);
        #1;
        frame(8'h5A, 1'b1);
        check_state("after_reset");
        check_eq("after_reset.rdata", int'(rdata), 8'h5A);
        check_eq("after_reset.count", int'(entries), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        check_eq("timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
